// File: rtl/program_loader_pkg.sv
// Shared types and helpers for the program loader: FSM state encoding and
// the number of stream bytes that make up one instruction word.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4,
        ERROR   = 3'd5
    } state_t;

    function automatic int bytes_per_word(input int instruction_size);
        return (instruction_size + 7) / 8;
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs MSB-first stream bytes into instruction words; the assembled word and
// word_complete are presented combinationally in the cycle of the final byte.
module word_assembler
    import program_loader_pkg::*;
#(
    parameter int instruction_size = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  in_byte,
    input  logic                        accept,
    input  logic                        clear,
    output logic [instruction_size-1:0] word,
    output logic                        word_complete
);

    localparam int BPW = bytes_per_word(instruction_size);
    localparam int CW  = $clog2(BPW) + 1;
    localparam int SRW = (BPW > 1) ? (BPW - 1) * 8 : 8;

    logic [SRW-1:0]   sr;
    logic [BPW*8-1:0] sr_next;
    logic [CW-1:0]    b;

    // Only the previous BPW-1 bytes need storing; the newest byte comes straight from the input.
    always_comb begin
        sr_next      = '0;
        sr_next[7:0] = in_byte;
        for (int i = 1; i < BPW; i++) begin
            sr_next[i*8 +: 8] = sr[(i-1)*8 +: 8];
        end
    end

    assign word          = sr_next[instruction_size-1:0];
    assign word_complete = accept && (b == CW'(BPW - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
            b  <= '0;
        end else if (clear) begin
            sr <= '0;
            b  <= '0;
        end else if (accept) begin
            sr <= sr_next[SRW-1:0];
            b  <= word_complete ? '0 : b + 1'b1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Streams a counted image into program memory while holding the core in reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
`ifndef PROGRAM_CODE_SIZE
`define PROGRAM_CODE_SIZE 4
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 24
`endif

module program_loader
    import program_loader_pkg::*;
#(
    parameter int program_code_size = `PROGRAM_CODE_SIZE,
    parameter int instruction_size  = `INSTRUCTION_SIZE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         wr_en,
    output logic [program_code_size-1:0] wr_addr,
    output logic [instruction_size-1:0]  wr_data,
    output logic                         cpu_hold,
    output logic                         done,
    output logic                         error
);

    localparam int unsigned MAX_WORDS = 32'd1 << program_code_size;
`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHECK;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t                      state, state_next;
    logic                        hs, accept, clear, last_word;
    logic                        word_complete;
    logic [instruction_size-1:0] word;
    logic [program_code_size:0]  w;
    logic [7:0]                  n_words;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]                  csum;
`endif

    assign hs        = in_valid && in_ready;
    assign accept    = hs && (state == PAYLOAD);
    assign clear     = (state_next == HEADER) && (state != HEADER);
    assign last_word = (32'(w) + 32'd1) == 32'(n_words);

    word_assembler #(.instruction_size(instruction_size)) u_asm (
        .clk          (clk),
        .reset        (reset),
        .in_byte      (in_data),
        .accept       (accept),
        .clear        (clear),
        .word         (word),
        .word_complete(word_complete)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = HEADER;
            HEADER: begin
                if (hs) begin
                    if (32'(in_data) > MAX_WORDS) state_next = ERROR;
                    else if (in_data == 8'd0)     state_next = END_STATE;
                    else                          state_next = PAYLOAD;
                end
            end
            PAYLOAD: if (word_complete && last_word) state_next = END_STATE;
`ifdef LOADER_CHECKSUM_EN
            CHECK:   if (hs) state_next = (in_data == csum) ? DONE : ERROR;
`endif
            DONE:    if (start) state_next = HEADER;
            ERROR:   if (start) state_next = HEADER;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they are registered yet track the state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            w        <= '0;
            n_words  <= '0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == HEADER) || (state_next == PAYLOAD) || (state_next == CHECK);
            cpu_hold <= (state_next != DONE);
            done     <= (state_next == DONE);
            error    <= (state_next == ERROR);
            wr_en    <= word_complete;
            if (clear) begin
                w <= '0;
            end else if (word_complete) begin
                wr_addr <= w[program_code_size-1:0];
                wr_data <= word;
                w       <= w + 1'b1;
            end
            if (state == HEADER && hs) n_words <= in_data;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     csum <= '0;
        else if (state == HEADER && hs) csum <= in_data;
        else if (accept)               csum <= csum ^ in_data;
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Randomised scoreboard bench for program_loader (program_code_size=4, instruction_size=24).
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, wr_en, cpu_hold, done, error;
    logic [3:0]  wr_addr;
    logic [23:0] wr_data;

    int          checks = 0;
    int          passes = 0;
    bit          idle_phase = 1'b0;
    logic [27:0] exp_q[$];
    logic [23:0] img[$];

    program_loader #(.program_code_size(4), .instruction_size(24)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .cpu_hold(cpu_hold),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every write strobe is matched against the head of the expected-write queue.
    logic [27:0] mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: addr %0h data %0h with no write expected", wr_addr, wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("write_addr_data", {4'h0, wr_addr, wr_data}, {4'h0, mon_e});
                end
            end
            if (done || error) chk("in_ready_low_done_error", {31'd0, in_ready}, 32'd0);
            if (idle_phase)    chk("in_ready_low_idle", {31'd0, in_ready}, 32'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit glitch);
        int guard;
        if (gaps) begin
            int g;
            g = $urandom_range(0, 3);
            in_valid = 1'b0;
            repeat (g) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        start    = glitch;
        guard    = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            $display("FAIL handshake_timeout: in_ready 0 for 100 cycles, byte %0h", b);
            in_valid = 1'b0;
            start    = 1'b0;
            return;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic fill_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(24'($urandom));
    endtask

    // Reference: count byte, then each word MSB-first; word i lands at address i.
    task automatic run_load(input logic [7:0] n, input bit gaps, input bit glitch, input bit do_start);
        logic [7:0] x;
        if (do_start) pulse_start();
        x = n;
        send_byte(n, gaps, glitch);
        if (n > 8'd16) begin
            in_valid = 1'b0;
            chk("oversize_error", {31'd0, error}, 32'd1);
            chk("oversize_cpu_hold", {31'd0, cpu_hold}, 32'd1);
            chk("oversize_done", {31'd0, done}, 32'd0);
            repeat (3) @(negedge clk);
            chk("oversize_no_writes", exp_q.size(), 32'd0);
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            logic [3:0]  a;
            logic [23:0] d;
            a = i[3:0];
            d = img[i];
            exp_q.push_back({a, d});
            for (int k = 2; k >= 0; k--) begin
                x = x ^ d[k*8 +: 8];
                send_byte(d[k*8 +: 8], gaps, glitch);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x, gaps, glitch);
`endif
        in_valid = 1'b0;
        chk("load_done", {31'd0, done}, 32'd1);
        chk("load_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("load_error", {31'd0, error}, 32'd0);
`ifndef LOADER_CHECKSUM_EN
        if (n != 8'd0) chk("last_wr_en_with_done", {31'd0, wr_en}, 32'd1);
`endif
        repeat (3) @(negedge clk);
        chk("all_writes_seen", exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {8'd0, wr_data}, 32'd0);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        reset = 1'b0;
        idle_phase = 1'b1;
        repeat (3) @(negedge clk);

        // start together with a byte in IDLE: the byte 05 must not be taken as the count
        idle_phase = 1'b0;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h05;
        @(negedge clk);
        start = 1'b0;
        img.delete();
        img.push_back(24'h123456);
        img.push_back(24'hABCDEF);
        run_load(8'd2, 1'b0, 1'b0, 1'b0);

        run_load(8'd2, 1'b1, 1'b0, 1'b1);
        fill_img(2);
        run_load(8'd2, 1'b0, 1'b1, 1'b1);

        run_load(8'h11, 1'b0, 1'b0, 1'b1);
        img.delete();
        img.push_back(24'h000001);
        run_load(8'd1, 1'b0, 1'b0, 1'b1);

        fill_img(16);
        run_load(8'd16, 1'b1, 1'b0, 1'b1);
        run_load(8'd0, 1'b0, 1'b0, 1'b1);
        for (int t = 0; t < 4; t++) begin
            int n;
            n = $urandom_range(1, 16);
            fill_img(n);
            run_load(8'(n), 1'b1, t[0], 1'b1);
        end
        run_load(8'hFF, 1'b1, 1'b0, 1'b1);

        // reset after four payload bytes: one word written, then nothing more
        fill_img(2);
        pulse_start();
        send_byte(8'd2, 1'b0, 1'b0);
        exp_q.push_back({4'd0, img[0]});
        for (int k = 2; k >= 0; k--) send_byte(img[0][k*8 +: 8], 1'b0, 1'b0);
        send_byte(img[1][23:16], 1'b0, 1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("midrst_wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("midrst_wr_data", {8'd0, wr_data}, 32'd0);
        chk("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_error", {31'd0, error}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_queue_empty", exp_q.size(), 32'd0);
        fill_img(3);
        run_load(8'd3, 1'b1, 1'b0, 1'b1);

`ifdef LOADER_CHECKSUM_EN
        img.delete();
        img.push_back(24'h0000FF);
        run_load(8'd1, 1'b0, 1'b0, 1'b1);
        pulse_start();
        send_byte(8'd1, 1'b0, 1'b0);
        exp_q.push_back({4'd0, 24'h0000FF});
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("csum_bad_error", {31'd0, error}, 32'd1);
        chk("csum_bad_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("csum_bad_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        chk("csum_bad_one_write", exp_q.size(), 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
